// File: rtl/bbpd_loop_filter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bbpd_loop_filter_pkg
//  Purpose  : Shared types, constants and saturation helpers for the
//             bang-bang phase detector loop filter.
//  Revision : 1.0 - initial release
// ============================================================================
package bbpd_loop_filter_pkg;

  // Width of the up=dn=1 (detector conflict) event counter.
  localparam int LF_ERR_CNT_W = 8;

  // Default integrator / output widths matching the reference configuration.
  localparam int LF_INT_WIDTH = 20;
  localparam int LF_OUT_WIDTH = 10;

  // Wide signed container for all PI arithmetic. It is wider than any
  // supported INT_WIDTH+2 so that sums never overflow before clamping.
  localparam int LF_WIDE_W = 40;

  typedef logic signed [LF_INT_WIDTH-1:0] lf_integ_t;
  typedef logic        [LF_OUT_WIDTH-1:0] lf_code_t;
  typedef logic signed [LF_WIDE_W-1:0]    lf_wide_t;

  // Clamp x into [lo, hi].
  function automatic lf_wide_t lf_clamp(input lf_wide_t x,
                                        input lf_wide_t lo,
                                        input lf_wide_t hi);
    lf_wide_t r;
    r = x;
    if (x > hi) r = hi;
    if (x < lo) r = lo;
    return r;
  endfunction

  // Signed saturation of x to a two's-complement range of width w.
  function automatic lf_wide_t lf_sat_signed(input lf_wide_t x, input int w);
    lf_wide_t hi;
    lf_wide_t lo;
    hi = (lf_wide_t'(1) <<< (w - 1)) - lf_wide_t'(1);
    lo = -(lf_wide_t'(1) <<< (w - 1));
    return lf_clamp(x, lo, hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bbpd_loop_filter_if.sv
`default_nettype none
// ============================================================================
//  Module   : bbpd_loop_filter_if
//  Purpose  : Detector-side inputs and control-code outputs of the loop
//             filter. The slave modport is the filter, the master modport is
//             whatever drives the detector decisions and consumes the code.
//  Revision : 1.0 - initial release
// ============================================================================
interface bbpd_loop_filter_if #(
  parameter int OUT_WIDTH = 10
);
  import bbpd_loop_filter_pkg::*;

  logic                    en;
  logic                    up;
  logic                    dn;
  logic [OUT_WIDTH-1:0]    code;
  logic                    code_valid;
  logic                    int_sat;
  logic [LF_ERR_CNT_W-1:0] err_cnt;

  modport master (
    output en, up, dn,
    input  code, code_valid, int_sat, err_cnt
  );

  modport slave (
    input  en, up, dn,
    output code, code_valid, int_sat, err_cnt
  );

endinterface
`default_nettype wire

// File: rtl/bbpd_loop_filter_vote_acc.sv
`default_nettype none
// ============================================================================
//  Module   : bbpd_vote_acc
//  Purpose  : Majority-vote accumulator. Sums per-UI up/dn decisions over a
//             VOTE_LEN window, flags window close with a combinational
//             win_done pulse and the window's vote, and counts up=dn=1
//             conflict cycles (saturating).
//  Revision : 1.0 - initial release
// ============================================================================
module bbpd_vote_acc
  import bbpd_loop_filter_pkg::*;
#(
  parameter int VOTE_LEN = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    up,
  input  logic                    dn,
  output logic signed [1:0]       vote,
  output logic                    win_done,
  output logic [LF_ERR_CNT_W-1:0] err_cnt
);

  localparam int CNT_W = (VOTE_LEN > 1) ? $clog2(VOTE_LEN) : 1;
  localparam int SUM_W = CNT_W + 2;

  logic [CNT_W-1:0]        win_cnt_q, win_cnt_d;
  logic signed [SUM_W-1:0] vote_sum_q, vote_sum_d;
  logic [LF_ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic signed [SUM_W-1:0] dec;
  logic signed [SUM_W-1:0] total;
  logic                    last;

  // Decision decode, window bookkeeping, vote and conflict counter.
  always_comb begin
    dec = '0;
    if (up && !dn) dec = SUM_W'(1);
    else if (dn && !up) dec = {SUM_W{1'b1}};

    // The closing cycle's own decision is part of the window total.
    total    = vote_sum_q + dec;
    last     = (win_cnt_q == CNT_W'(VOTE_LEN - 1));
    win_done = en && last;

    vote = 2'sb00;
    if (total > 0) vote = 2'sb01;
    else if (total < 0) vote = 2'sb11;

    win_cnt_d  = win_cnt_q;
    vote_sum_d = vote_sum_q;
    err_cnt_d  = err_cnt_q;
    if (en) begin
      if (last) begin
        win_cnt_d  = '0;
        vote_sum_d = '0;
      end else begin
        win_cnt_d  = win_cnt_q + CNT_W'(1);
        vote_sum_d = total;
      end
      if (up && dn && (err_cnt_q != {LF_ERR_CNT_W{1'b1}})) begin
        err_cnt_d = err_cnt_q + LF_ERR_CNT_W'(1);
      end
    end
  end

  // Accumulator state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_cnt_q  <= '0;
      vote_sum_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      win_cnt_q  <= win_cnt_d;
      vote_sum_q <= vote_sum_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;

endmodule
`default_nettype wire

// File: rtl/bbpd_loop_filter.sv
`default_nettype none
// ============================================================================
//  Module   : bbpd_loop_filter
//  Purpose  : Proportional-plus-integral loop filter for a bang-bang phase
//             detector. Stage 1 integrates the window vote with saturation;
//             stage 2 forms the clamped control code and pulses code_valid.
//  Revision : 1.0 - initial release
// ============================================================================
module bbpd_loop_filter
  import bbpd_loop_filter_pkg::*;
#(
  parameter int VOTE_LEN  = 16,
  parameter int KP_SHIFT  = 4,
  parameter int KI_SHIFT  = 0,
  parameter int INT_FRAC  = 4,
  parameter int INT_WIDTH = 20,
  parameter int OUT_WIDTH = 10,
  parameter int OUT_INIT  = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  bbpd_loop_filter_if.slave lf
);

  localparam logic signed [INT_WIDTH-1:0] INT_MAX = {1'b0, {(INT_WIDTH-1){1'b1}}};
  localparam logic signed [INT_WIDTH-1:0] INT_MIN = {1'b1, {(INT_WIDTH-1){1'b0}}};
  localparam logic [OUT_WIDTH-1:0]        CODE_INIT = OUT_WIDTH'(OUT_INIT);

  logic signed [1:0]       vote_w;
  logic                    win_done_w;
  logic [LF_ERR_CNT_W-1:0] err_cnt_w;

  logic signed [INT_WIDTH-1:0] integ_q, integ_d;
  logic signed [1:0]           vote_q, vote_d;
  logic                        s1_valid_q, s1_valid_d;
  logic                        int_sat_q, int_sat_d;
  logic [OUT_WIDTH-1:0]        code_q, code_d;
  logic                        code_valid_q, code_valid_d;
  lf_wide_t                    integ_sum;
  lf_wide_t                    code_sum;

  bbpd_vote_acc #(
    .VOTE_LEN (VOTE_LEN)
  ) u_vote_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (lf.en),
    .up       (lf.up),
    .dn       (lf.dn),
    .vote     (vote_w),
    .win_done (win_done_w),
    .err_cnt  (err_cnt_w)
  );

  // Stage 1: saturating integrator update and vote capture at window close.
  always_comb begin
    integ_sum  = lf_wide_t'(integ_q) + (lf_wide_t'(vote_w) <<< KI_SHIFT);
    integ_d    = integ_q;
    vote_d     = vote_q;
    s1_valid_d = 1'b0;
    if (win_done_w) begin
      integ_d    = INT_WIDTH'(lf_sat_signed(integ_sum, INT_WIDTH));
      vote_d     = vote_w;
      s1_valid_d = 1'b1;
    end
    int_sat_d = (integ_d == INT_MAX) || (integ_d == INT_MIN);
  end

  // Stage 2: PI sum and output clamp; runs regardless of en so an update
  // already in flight always lands.
  always_comb begin
    code_sum = lf_wide_t'(OUT_INIT)
             + (lf_wide_t'(integ_q) >>> INT_FRAC)
             + (lf_wide_t'(vote_q) <<< KP_SHIFT);
    code_d       = code_q;
    code_valid_d = s1_valid_q;
    if (s1_valid_q) begin
      code_d = OUT_WIDTH'(lf_clamp(code_sum, lf_wide_t'(0),
                                   (lf_wide_t'(1) <<< OUT_WIDTH) - lf_wide_t'(1)));
    end
  end

  // Pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      integ_q      <= '0;
      vote_q       <= '0;
      s1_valid_q   <= 1'b0;
      int_sat_q    <= 1'b0;
      code_q       <= CODE_INIT;
      code_valid_q <= 1'b0;
    end else begin
      integ_q      <= integ_d;
      vote_q       <= vote_d;
      s1_valid_q   <= s1_valid_d;
      int_sat_q    <= int_sat_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
    end
  end

  assign lf.code       = code_q;
  assign lf.code_valid = code_valid_q;
  assign lf.int_sat    = int_sat_q;
  assign lf.err_cnt    = err_cnt_w;

endmodule
`default_nettype wire

// File: tb/tb_bbpd_loop_filter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bbpd_loop_filter
//  Purpose  : Self-checking bench for bbpd_loop_filter. Two instances share
//             stimulus: the reference configuration and an INT_WIDTH=8 one
//             that reaches integrator saturation quickly.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bbpd_loop_filter;

  typedef struct {
    int due;
    int code;
    bit sat;
  } exp_t;

  typedef struct {
    int nu;
    int nd;
    int nb;
    int code;
    bit sat;
    int err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  bbpd_loop_filter_if #(.OUT_WIDTH(10)) if_a ();
  bbpd_loop_filter_if #(.OUT_WIDTH(10)) if_b ();

  assign if_b.en = if_a.en;
  assign if_b.up = if_a.up;
  assign if_b.dn = if_a.dn;

  bbpd_loop_filter dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .lf    (if_a)
  );

  bbpd_loop_filter #(.INT_WIDTH(8)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .lf    (if_b)
  );

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cnt_neg  = 0;

  int m_sum;
  int m_cnt;
  int m_err;
  int m_integ [2];
  int m_lo    [2];
  int m_hi    [2];

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference model: one enabled cycle of decisions; at window close it
  // pushes the expected code for both instances.
  task automatic model_step(input bit e, input bit u, input bit d);
    int   dv;
    int   vote;
    int   code;
    exp_t x;
    if (e) begin
      dv = (u && !d) ? 1 : ((d && !u) ? -1 : 0);
      if (u && d && m_err < 255) m_err++;
      m_sum += dv;
      if (m_cnt == 15) begin
        vote = (m_sum > 0) ? 1 : ((m_sum < 0) ? -1 : 0);
        for (int k = 0; k < 2; k++) begin
          m_integ[k] += vote;
          if (m_integ[k] > m_hi[k]) m_integ[k] = m_hi[k];
          if (m_integ[k] < m_lo[k]) m_integ[k] = m_lo[k];
          code = 512 + (m_integ[k] >>> 4) + vote * 16;
          if (code > 1023) code = 1023;
          if (code < 0) code = 0;
          x.due  = cnt_neg + 3;
          x.code = code;
          x.sat  = (m_integ[k] == m_hi[k]) || (m_integ[k] == m_lo[k]);
          if (k == 0) q0.push_back(x);
          else        q1.push_back(x);
        end
        m_cnt = 0;
        m_sum = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic sb_port(input int k, input logic v, input logic [9:0] c, input logic s);
    exp_t e;
    int   sz;
    sz = (k == 0) ? q0.size() : q1.size();
    if (sz > 0) begin
      e = (k == 0) ? q0[0] : q1[0];
      if (e.due < cnt_neg) begin
        chk((k == 0) ? "sb_a_missing_valid" : "sb_b_missing_valid", cnt_neg, e.due);
        if (k == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
        sz--;
      end
    end
    if (v) begin
      if (sz == 0) begin
        chk((k == 0) ? "sb_a_unexpected_valid" : "sb_b_unexpected_valid", 1, 0);
      end else begin
        if (k == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk((k == 0) ? "sb_a_valid_cycle" : "sb_b_valid_cycle", cnt_neg, e.due);
        chk((k == 0) ? "sb_a_code" : "sb_b_code", c, e.code);
        chk((k == 0) ? "sb_a_int_sat" : "sb_b_int_sat", s, e.sat);
      end
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cnt_neg++;
    if (rst_n) begin
      sb_port(0, if_a.code_valid, if_a.code, if_a.int_sat);
      sb_port(1, if_b.code_valid, if_b.code, if_b.int_sat);
    end
  end

  task automatic cyc(input bit e, input bit u, input bit d);
    if_a.en = e;
    if_a.up = u;
    if_a.dn = d;
    model_step(e, u, d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    if_a.en = 1'b0;
    if_a.up = 1'b0;
    if_a.dn = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q0.delete();
    q1.delete();
    m_sum = 0;
    m_cnt = 0;
    m_err = 0;
    m_integ[0] = 0;
    m_integ[1] = 0;
  endtask

  task automatic window(input int nu, input int nd, input int nb);
    for (int i = 0; i < 16; i++) begin
      if (i < nu)                cyc(1'b1, 1'b1, 1'b0);
      else if (i < nu + nd)      cyc(1'b1, 1'b0, 1'b1);
      else if (i < nu + nd + nb) cyc(1'b1, 1'b1, 1'b1);
      else                       cyc(1'b1, 1'b0, 1'b0);
    end
  endtask

  vec_t tbl [6];

  initial begin
    tbl[0] = '{nu:16, nd:0,  nb:0,  code:528, sat:1'b0, err:0};
    tbl[1] = '{nu:8,  nd:8,  nb:0,  code:512, sat:1'b0, err:0};
    tbl[2] = '{nu:4,  nd:12, nb:0,  code:496, sat:1'b0, err:0};
    tbl[3] = '{nu:0,  nd:0,  nb:16, code:512, sat:1'b0, err:16};
    tbl[4] = '{nu:9,  nd:7,  nb:0,  code:528, sat:1'b0, err:16};
    tbl[5] = '{nu:1,  nd:0,  nb:0,  code:528, sat:1'b0, err:16};
    m_lo[0] = -524288; m_hi[0] = 524287;
    m_lo[1] = -128;    m_hi[1] = 127;

    do_reset();
    chk("reset_code", if_a.code, 512);
    chk("reset_code_valid", if_a.code_valid, 0);
    chk("reset_int_sat", if_a.int_sat, 0);
    chk("reset_err_cnt", if_a.err_cnt, 0);
    chk("reset_code_b", if_b.code, 512);

    // Window table; one en=0 cycle after each window lets stage 2 land.
    for (int i = 0; i < 6; i++) begin
      window(tbl[i].nu, tbl[i].nd, tbl[i].nb);
      chk("tbl_valid_before", if_a.code_valid, 0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("tbl_valid", if_a.code_valid, 1);
      chk("tbl_code", if_a.code, tbl[i].code);
      chk("tbl_int_sat", if_a.int_sat, tbl[i].sat);
      chk("tbl_err_cnt", if_a.err_cnt, tbl[i].err);
      cyc(1'b0, 1'b0, 1'b0);
      chk("tbl_valid_after", if_a.code_valid, 0);
    end

    // Reset in the middle of a window.
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0);
    do_reset();
    chk("midrst_code", if_a.code, 512);
    chk("midrst_err_cnt", if_a.err_cnt, 0);
    chk("midrst_code_valid", if_a.code_valid, 0);
    chk("midrst_int_sat", if_a.int_sat, 0);

    // Sixteen all-up windows then one all-dn window.
    for (int w = 0; w < 16; w++) window(16, 0, 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("up16_code", if_a.code, 529);
    window(0, 16, 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("dn1_code", if_a.code, 496);

    // Enable dropped for 5 cycles mid-window delays the close by 5 cycles.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1);
    chk("en_hold_err_cnt", if_a.err_cnt, 0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0);
    chk("en_hold_code_pending", if_a.code, 512);
    cyc(1'b1, 1'b0, 1'b0);
    chk("en_hold_code", if_a.code, 528);
    chk("en_hold_valid", if_a.code_valid, 1);

    // Conflict counter saturates.
    do_reset();
    for (int i = 0; i < 300; i++) cyc(1'b1, 1'b1, 1'b1);
    chk("err_cnt_sat", if_a.err_cnt, 255);
    cyc(1'b1, 1'b1, 1'b1);
    chk("err_cnt_nowrap", if_a.err_cnt, 255);

    // Integrator saturation on the narrow instance.
    do_reset();
    for (int w = 0; w < 200; w++) window(16, 0, 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("stress_b_code", if_b.code, 535);
    chk("stress_b_int_sat", if_b.int_sat, 1);
    chk("stress_a_code", if_a.code, 540);
    chk("stress_a_int_sat", if_a.int_sat, 0);

    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0);
    chk("sb_a_drained", q0.size(), 0);
    chk("sb_b_drained", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
